// File: rtl/regfile_write_queue.sv
// Write-back FIFO in front of the 32x32 register file, with a youngest-match forwarding lookup.
// Optional build macro REGFILE_WQ_ZERO_DISCARD_EN: drop writes to register 0 and never forward it.
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic                         WbValid,
    output logic                         WbReady,
    input  logic [AW-1:0]                WbAddr,
    input  logic [DW-1:0]                WbData,
    input  logic                         Stall,
    input  logic                         Flush,
    output logic [AW-1:0]                AWR,
    output logic [DW-1:0]                DataIn,
    output logic                         WE,
    input  logic [AW-1:0]                QAddr,
    output logic                         QHit,
    output logic [DW-1:0]                QData,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // state     | meaning
    // ST_EMPTY  | no queued entries
    // ST_ACTIVE | 0 < count < DEPTH
    // ST_FULL   | count == DEPTH, WbReady low
    typedef enum logic [1:0] {ST_EMPTY, ST_ACTIVE, ST_FULL} state_t;

    state_t          state;
    logic [AW-1:0]   q_addr [DEPTH];
    logic [DW-1:0]   q_data [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   fwd_idx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            accept;
    logic            push;
    logic            pop;

    assign WbReady = (state != ST_FULL);
    assign accept  = WbValid & WbReady & ~Flush;
`ifdef REGFILE_WQ_ZERO_DISCARD_EN
    assign push    = accept & (WbAddr != '0);
`else
    assign push    = accept;
`endif
    assign pop     = (state != ST_EMPTY) & ~Stall & ~Flush;
    assign Count   = cnt;

    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop)
            cnt_nxt = cnt + CW'(1);
        else if (pop && !push)
            cnt_nxt = cnt - CW'(1);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= ST_EMPTY;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            AWR    <= '0;
            DataIn <= '0;
            WE     <= 1'b0;
        end else if (Flush) begin
            state  <= ST_EMPTY;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            WE     <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                AWR    <= q_addr[rd_ptr];
                DataIn <= q_data[rd_ptr];
            end
            WE  <= pop;
            cnt <= cnt_nxt;
            if (cnt_nxt == '0)
                state <= ST_EMPTY;
            else if (cnt_nxt == CW'(DEPTH))
                state <= ST_FULL;
            else
                state <= ST_ACTIVE;
        end
    end

    // Queue storage needs no reset: nothing is visible unless covered by cnt.
    always_ff @(posedge Clk) begin
        if (push) begin
            q_addr[wr_ptr] <= WbAddr;
            q_data[wr_ptr] <= WbData;
        end
    end

    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        QHit    = 1'b0;
        QData   = '0;
        fwd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PW'(i);
            if ((CW'(i) < cnt) && (q_addr[fwd_idx] == QAddr)) begin
                QHit  = 1'b1;
                QData = q_data[fwd_idx];
            end
        end
`ifdef REGFILE_WQ_ZERO_DISCARD_EN
        if (QAddr == '0) begin
            QHit  = 1'b0;
            QData = '0;
        end
`endif
    end

endmodule
